frame_flip_controller: RTL and testbench
========================================

Name: frame_flip_controller

Overview:
Double-buffered frame memory plus the controller that sequences it for the display path. The SPI loader writes pixel words into the back bank. The row scanner reads the front bank. A load-complete pulse from the loader schedules a bank swap at the next scanner end-of-frame. After the swap, the controller copies the new front bank into the new back bank so partial row updates stay coherent. `ready` returns high to the loader only when the copy is finished.

Parameters:
- segments, 1, number of chained panel segments per column word
- bitwidth, 8, bits per colour channel
- rows, 8, addressable rows; power of 2
- columns, 32, columns per row; power of 2
- WORD = segments*bitwidth*3 (derived, not overridable)
- DEPTH = rows*columns (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- w_en  in  1  loader write strobe
- w_row  in  clog2(rows)  loader write row
- w_col  in  clog2(columns)  loader write column
- w_data  in  WORD  loader write word
- loaded  in  1  one-cycle pulse: back bank complete, request flip
- ready  out  1  high = back bank accepts writes; the loader detects the 0->1 edge
- r_row  in  clog2(rows)  scanner read row
- r_col  in  clog2(columns)  scanner read column
- r_data  out  WORD  scanner read data from front bank, registered
- frame_end  in  1  one-cycle pulse from scanner after last row shown
- front  out  1  current front bank index
- flip_count  out  8  completed flips, wraps 255->0
- overrun  out  1  sticky: a write arrived while not IDLE

Behaviour:
- Addressing and storage
  - Address = {row, col}; the column field is the low bits.
  - Two banks, DEPTH x WORD each.
  - Port A of each bank is controller read/write; port B is scanner read.
  - Memory contents are not reset.
- Reset values: ready=1, front=0, flip_count=0, overrun=0, r_data=0, state=IDLE, copy counter=0.
- Scanner read path
  - r_data is valid 1 cycle after r_row/r_col are presented.
  - It reads the bank selected by `front` as sampled on that same edge.
  - A read issued in the cycle whose edge toggles `front` returns old-front data.
  - The scanner read path is independent of state and never stalls.
- State IDLE, ready=1
  - w_en writes w_data into bank !front at {w_row, w_col} on that edge.
  - loaded -> PENDING.
  - If w_en and loaded coincide, the write is performed and then the state moves to PENDING.
  - frame_end is ignored in IDLE.
  - If loaded and frame_end coincide, the state goes to PENDING and that frame_end is not consumed.
- State PENDING, ready=0
  - Waits for frame_end.
  - On frame_end: front toggles, flip_count increments (mod 256), copy counter clears, state -> COPY.
- State COPY, ready=0
  - Each cycle: read new-front port A at counter, counter++.
  - One cycle later, write that word into the new back bank at counter-1.
  - After the read of DEPTH-1 issues, one drain cycle performs the final write, then the state goes to IDLE.
  - COPY occupies exactly DEPTH+1 cycles. ready rises on the edge leaving COPY.
  - frame_end and loaded are ignored during COPY.
- Writes outside IDLE
  - Any w_en while not in IDLE is dropped with no memory change, and sets overrun=1.
  - overrun clears only on rst.
- loaded in PENDING or COPY is ignored; there is no queueing.
- Reset mid-operation (any state): the next cycle shows reset values, the state is IDLE, and any in-progress copy is abandoned. Bank contents may be partially copied.
- Width rules
  - The copy counter is clog2(DEPTH)+1 bits wide to detect completion without wrap.
  - flip_count wraps silently.

Test Plan:
1. Reset, then hold 5 cycles -> ready=1, front=0, flip_count=0, overrun=0, r_data=0.
2. Write 0xA5B6C7 at (3,5); pulse loaded; pulse frame_end 10 cycles later.
   - front=1 on the edge after frame_end.
   - ready=0 for exactly 257 cycles, then 1.
   - flip_count=1.
   - r_row=3, r_col=5 returns 0xA5B6C7 one cycle later.
3. After scenario 2, write only 0x111111 at (0,0), then loaded, then frame_end.
   - front=0.
   - (0,0) reads 0x111111.
   - (3,5) still reads 0xA5B6C7, which proves the copy.
4. Pulse loaded, then w_en at (1,1)=0xFFFFFF while PENDING.
   - overrun=1 and stays 1.
   - After the flip, (1,1) does not read 0xFFFFFF.
5. loaded and frame_end in the same cycle -> front unchanged and ready=0; the flip occurs only at the next frame_end.
6. Assert rst 100 cycles into COPY -> next cycle ready=1, front=0, flip_count=0; a subsequent write plus loaded plus frame_end flips normally.

Source files
------------

// File: rtl/frame_flip_controller.sv
// Double-buffered frame memory with a flip controller: the loader fills the back bank,
// the scanner reads the front bank, and after each swap the new front is copied into the new back.
module frame_flip_controller #(
  parameter int segments = 1,
  parameter int bitwidth = 8,
  parameter int rows     = 8,
  parameter int columns  = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              w_en,
  input  logic [$clog2(rows)-1:0]           w_row,
  input  logic [$clog2(columns)-1:0]        w_col,
  input  logic [segments*bitwidth*3-1:0]    w_data,
  input  logic                              loaded,
  output logic                              ready,
  input  logic [$clog2(rows)-1:0]           r_row,
  input  logic [$clog2(columns)-1:0]        r_col,
  output logic [segments*bitwidth*3-1:0]    r_data,
  input  logic                              frame_end,
  output logic                              front,
  output logic [7:0]                        flip_count,
  output logic                              overrun
);

  localparam int WORD  = segments * bitwidth * 3;
  localparam int DEPTH = rows * columns;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {IDLE, PENDING, COPY} state_t;

  state_t          state_reg, state_next;
  logic            front_reg, front_next;
  logic [7:0]      flip_reg, flip_next;
  logic            overrun_reg, overrun_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            pend_reg, pend_next;
  logic [AW-1:0]   paddr_reg, paddr_next;
  logic            sel_reg;
  logic            copy_rd;

  logic [AW-1:0]   w_addr;
  logic [AW-1:0]   r_addr;
  logic [WORD-1:0] copy_data;
  logic [WORD-1:0] wdata;

  assign w_addr = {w_row, w_col};
  assign r_addr = {r_row, r_col};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      front_reg   <= 1'b0;
      flip_reg    <= 8'd0;
      overrun_reg <= 1'b0;
      cnt_reg     <= '0;
      pend_reg    <= 1'b0;
      paddr_reg   <= '0;
      sel_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      front_reg   <= front_next;
      flip_reg    <= flip_next;
      overrun_reg <= overrun_next;
      cnt_reg     <= cnt_next;
      pend_reg    <= pend_next;
      paddr_reg   <= paddr_next;
      // Bank select for the scanner follows the front value seen on the read's own edge
      sel_reg     <= front_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    front_next   = front_reg;
    flip_next    = flip_reg;
    overrun_next = overrun_reg | (w_en && (state_reg != IDLE));
    cnt_next     = cnt_reg;
    pend_next    = 1'b0;
    paddr_next   = paddr_reg;
    copy_rd      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (loaded) state_next = PENDING;
      end
      PENDING: begin
        if (frame_end) begin
          front_next = ~front_reg;
          flip_next  = flip_reg + 8'd1;
          cnt_next   = '0;
          state_next = COPY;
        end
      end
      COPY: begin
        // Read address cnt now; its word is written to the back bank next cycle
        if (cnt_reg < CW'(DEPTH)) begin
          copy_rd    = 1'b1;
          pend_next  = 1'b1;
          paddr_next = cnt_reg[AW-1:0];
          cnt_next   = cnt_reg + 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign wdata = pend_reg ? copy_data : w_data;

  for (genvar gi = 0; gi < 2; gi++) begin : bank
    logic [WORD-1:0] mem [DEPTH];
    logic [WORD-1:0] qa;
    logic [WORD-1:0] qb;
    logic [AW-1:0]   addr;
    logic            is_front;
    logic            we;

    assign is_front = (front_reg == 1'(gi));
    assign we = !is_front && (pend_reg || (state_reg == IDLE && w_en));

    always_comb begin
      addr = w_addr;
      if (pend_reg && !is_front) addr = paddr_reg;
      else if (copy_rd && is_front) addr = cnt_reg[AW-1:0];
    end

    always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      qa <= mem[addr];
    end

    always_ff @(posedge clk) begin
      if (rst) qb <= '0;
      else     qb <= mem[r_addr];
    end
  end

  assign copy_data  = front_reg ? bank[1].qa : bank[0].qa;
  assign r_data     = sel_reg ? bank[1].qb : bank[0].qb;
  assign ready      = (state_reg == IDLE);
  assign front      = front_reg;
  assign flip_count = flip_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_frame_flip_controller.sv
// Scoreboard bench: the driver updates an array-level model per edge and queues expectations;
// a negedge monitor pops them and compares against the DUT outputs.
module tb_frame_flip_controller;
  localparam int ROWS = 8, COLS = 32, WORD = 24, DEPTH = ROWS * COLS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1, w_en = 1'b0, loaded = 1'b0, frame_end = 1'b0;
  logic [2:0]      w_row = '0, r_row = '0;
  logic [4:0]      w_col = '0, r_col = '0;
  logic [WORD-1:0] w_data = '0;
  logic            ready, front, overrun;
  logic [WORD-1:0] r_data;
  logic [7:0]      flip_count;

  frame_flip_controller #(.segments(1), .bitwidth(8), .rows(ROWS), .columns(COLS)) dut (
    .clk(clk), .rst(rst), .w_en(w_en), .w_row(w_row), .w_col(w_col), .w_data(w_data),
    .loaded(loaded), .ready(ready), .r_row(r_row), .r_col(r_col), .r_data(r_data),
    .frame_end(frame_end), .front(front), .flip_count(flip_count), .overrun(overrun)
  );

  typedef struct {
    logic            ready;
    logic            front;
    logic [7:0]      flip;
    logic            overrun;
    logic            rd_known;
    logic [WORD-1:0] rd;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: whole-bank view, copy happens instantly at the flip
  logic [WORD-1:0] mbank  [2][DEPTH];
  bit              mknown [2][DEPTH];
  int              mstate = 0;   // 0 idle, 1 waiting for frame end, 2 copying
  int              mleft  = 0;
  int              mfront = 0;
  int              mflip  = 0;
  bit              movr   = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic model_edge();
    exp_t e;
    int waddr, raddr, b;
    waddr = {w_row, w_col};
    raddr = {r_row, r_col};
    if (rst) begin
      if (mstate == 2)
        for (int a = 0; a < DEPTH; a++) mknown[1 - mfront][a] = 1'b0;
      mstate = 0; mfront = 0; mflip = 0; movr = 1'b0; mleft = 0;
      e.rd = '0; e.rd_known = 1'b1;
    end else begin
      e.rd = mbank[mfront][raddr];
      e.rd_known = mknown[mfront][raddr];
      if (w_en && mstate != 0) movr = 1'b1;
      case (mstate)
        0: begin
          if (w_en) begin
            mbank[1 - mfront][waddr] = w_data;
            mknown[1 - mfront][waddr] = 1'b1;
          end
          if (loaded) mstate = 1;
        end
        1: begin
          if (frame_end) begin
            mfront = 1 - mfront;
            mflip = (mflip + 1) % 256;
            b = 1 - mfront;
            for (int a = 0; a < DEPTH; a++) begin
              mbank[b][a] = mbank[mfront][a];
              mknown[b][a] = mknown[mfront][a];
            end
            mstate = 2;
            mleft = DEPTH + 1;
          end
        end
        default: begin
          mleft--;
          if (mleft == 0) mstate = 0;
        end
      endcase
    end
    e.ready = (mstate == 0);
    e.front = mfront[0];
    e.flip = mflip[7:0];
    e.overrun = movr;
    sb.push_back(e);
  endtask

  // Called at a negedge; drives one cycle of inputs, returns at the next negedge
  task automatic step(input bit s_rst, input bit we, input int wr, input int wc,
                      input logic [WORD-1:0] wd, input bit ld, input bit fe,
                      input int rr = -1, input int rc = -1);
    rst = s_rst; w_en = we; w_row = wr[2:0]; w_col = wc[4:0]; w_data = wd;
    loaded = ld; frame_end = fe;
    r_row = (rr < 0) ? 3'($urandom_range(0, ROWS - 1)) : rr[2:0];
    r_col = (rc < 0) ? 5'($urandom_range(0, COLS - 1)) : rc[4:0];
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic wr(input int r, input int c, input logic [WORD-1:0] d);
    step(0, 1, r, c, d, 0, 0);
  endtask

  task automatic rd(input int r, input int c);
    step(0, 0, 0, 0, '0, 0, 0, r, c);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ready", 32'(ready), 32'(e.ready));
      chk("front", 32'(front), 32'(e.front));
      chk("flip_count", 32'(flip_count), 32'(e.flip));
      chk("overrun", 32'(overrun), 32'(e.overrun));
      if (e.rd_known) chk("r_data", 32'(r_data), 32'(e.rd));
    end
  end

  initial begin
    @(negedge clk);
    // Reset and hold
    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    idle(5);
    // Fill the back bank completely, then flip so both banks hold known data
    for (int a = 0; a < DEPTH; a++)
      wr(a / COLS, a % COLS, WORD'($urandom_range(0, 24'hFFFFFE)));
    step(0, 0, 0, 0, '0, 1, 0);
    idle(10);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(DEPTH + 4);
    // Single pixel update then flip; read it back after the swap
    wr(3, 5, 24'hA5B6C7);
    step(0, 0, 0, 0, '0, 1, 0);
    idle(10);
    step(0, 0, 0, 0, '0, 0, 1);
    rd(3, 5);
    rd(3, 5);
    idle(DEPTH + 4);
    // Partial update: untouched pixel must survive through the copy
    wr(0, 0, 24'h111111);
    step(0, 0, 0, 0, '0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, '0, 0, 1);
    rd(0, 0);
    rd(3, 5);
    idle(DEPTH + 4);
    rd(3, 5);
    // Write while pending is dropped and flags overrun
    step(0, 0, 0, 0, '0, 1, 0);
    wr(1, 1, 24'hFFFFFF);
    idle(3);
    step(0, 0, 0, 0, '0, 0, 1);
    rd(1, 1);
    idle(DEPTH + 4);
    rd(1, 1);
    // loaded and frame_end together: the frame_end is not consumed
    step(0, 0, 0, 0, '0, 1, 1);
    idle(5);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(DEPTH + 4);
    // Reset 100 cycles into a copy, then a normal flip
    step(0, 0, 0, 0, '0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(100);
    step(1, 0, 0, 0, '0, 0, 0);
    idle(2);
    wr(2, 7, 24'h0C0FFE);
    step(0, 0, 0, 0, '0, 1, 0);
    idle(3);
    step(0, 0, 0, 0, '0, 0, 1);
    rd(2, 7);
    idle(DEPTH + 4);
    rd(2, 7);
    // Randomized traffic: writes in any state, sporadic loaded/frame_end, rare reset
    for (int i = 0; i < 6000; i++) begin
      step(($urandom_range(0, 1999) == 0),
           ($urandom_range(0, 1) == 1),
           int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
           WORD'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 29) == 0));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
